// File: rtl/count_seq_ctrl_pkg.sv
// Shared state encoding for the count sequence controller.
// Optional build macro COUNT_DOWN_EN adds a count-direction input (see count_seq_ctrl).
package count_seq_pkg;
   localparam int STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE  = 2'b00;
   localparam state_t ST_RUN   = 2'b01;
   localparam state_t ST_PAUSE = 2'b10;
   localparam state_t ST_DONE  = 2'b11;
endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command/status bundle between a CPU-style master and the count sequence controller.
// With COUNT_DOWN_EN defined, the bundle also carries the count direction bit.
interface count_seq_ctrl_if
   import count_seq_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 4
);
   // Commands are level-sampled on every rising clk edge (no handshake); the
   // master holds cmd_start/cmd_stop for one clock to issue a single command.
   logic                  cmd_start;
   logic                  cmd_stop;
   logic                  mode_reload;
   logic [WIDTH-1:0]      load_val;
   logic [WIDTH-1:0]      terminal;
   logic [PRESCALE_W-1:0] presc;
`ifdef COUNT_DOWN_EN
   logic                  dir;
`endif
   logic [WIDTH-1:0]      count;
   logic [STATE_W-1:0]    state;
   logic                  busy;
   logic                  done;

   modport master (
`ifdef COUNT_DOWN_EN
      output dir,
`endif
      output cmd_start, cmd_stop, mode_reload, load_val, terminal, presc,
      input  count, state, busy, done
   );

   modport slave (
`ifdef COUNT_DOWN_EN
      input  dir,
`endif
      input  cmd_start, cmd_stop, mode_reload, load_val, terminal, presc,
      output count, state, busy, done
   );
endinterface

// File: rtl/count_seq_ctrl_prescaler.sv
// Clock prescaler: emits an advance strobe every presc+1 clocks while run is high.
// clr restarts the divider and takes priority over run; the value freezes while run is low.
module count_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] presc,
   output logic                  advance
);
   logic [PRESCALE_W-1:0] r_cnt;
   logic                  w_hit;

   assign w_hit   = (r_cnt == presc);
   assign advance = run & ~clr & w_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (run) begin
         if (w_hit) r_cnt <= '0;
         else       r_cnt <= r_cnt + PRESCALE_W'(1);
      end
   end
endmodule

// File: rtl/count_seq_ctrl.sv
// Run/pause/stop controller owning the event count register, terminal compare and done pulse.
// Define COUNT_DOWN_EN to add the dir input (1 = decrement); default build counts up only.
module count_seq_ctrl
   import count_seq_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 4
) (
   input logic             clk,
   input logic             reset,
   count_seq_ctrl_if.slave bus
);
   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_count;
   logic             r_done;

   logic             w_run;
   logic             w_load;
   logic             w_advance;
   logic [WIDTH-1:0] w_step;
   logic             w_match;

   assign w_run  = (r_state == ST_RUN);
   // Stop wins over start, so a simultaneous pair never launches a run.
   assign w_load = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                   bus.cmd_start && !bus.cmd_stop;

   count_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .run     (w_run),
      .clr     (w_load),
      .presc   (bus.presc),
      .advance (w_advance)
   );

`ifdef COUNT_DOWN_EN
   assign w_step = bus.dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
`else
   assign w_step = r_count + WIDTH'(1);
`endif

   // Compare only the advanced value; a load never produces a match.
   assign w_match = w_advance && (w_step == bus.terminal);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_load) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            // A one-shot match completes before any stop in the same cycle.
            if (w_match && !bus.mode_reload) w_next_state = ST_DONE;
            else if (bus.cmd_stop)           w_next_state = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (bus.cmd_stop)       w_next_state = ST_IDLE;
            else if (bus.cmd_start) w_next_state = ST_RUN;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_match;
         if (w_load) begin
            r_count <= bus.load_val;
         end else if (w_advance) begin
            if (w_match && bus.mode_reload) r_count <= bus.load_val;
            else                            r_count <= w_step;
         end
      end
   end

   always_comb begin
      bus.count = r_count;
      bus.state = r_state;
      bus.done  = r_done;
      bus.busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl; the down-count steps build only with COUNT_DOWN_EN.
module tb_count_seq_ctrl;
   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   count_seq_ctrl_if #(.WIDTH(4), .PRESCALE_W(4)) u_if ();

   count_seq_ctrl #(
      .WIDTH      (4),
      .PRESCALE_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      u_if.cmd_start   = 1'b0;
      u_if.cmd_stop    = 1'b0;
      u_if.mode_reload = 1'b0;
      u_if.load_val    = 4'd0;
      u_if.terminal    = 4'd0;
      u_if.presc       = 4'd0;
`ifdef COUNT_DOWN_EN
      u_if.dir = 1'b0;
`endif

      // ---- reset values ----
      #1 reset = 1'b1;
      #1;
      chk("rst_count", u_if.count, 4'd0);
      chk("rst_state", u_if.state, 2'b00);
      chk("rst_busy",  u_if.busy,  1'b0);
      chk("rst_done",  u_if.done,  1'b0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // ---- one-shot 3..7 ----
      u_if.load_val = 4'd3; u_if.terminal = 4'd7; u_if.presc = 4'd0; u_if.mode_reload = 1'b0;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("os_load",  u_if.count, 4'd3);
      chk("os_state", u_if.state, 2'b01);
      chk("os_busy",  u_if.busy,  1'b1);
      for (int v = 4; v <= 6; v++) begin
         tick();
         chk("os_count", u_if.count, 32'(v));
         chk("os_nodone", u_if.done, 1'b0);
      end
      tick();
      chk("os_term_count", u_if.count, 4'd7);
      chk("os_done",       u_if.done,  1'b1);
      chk("os_done_state", u_if.state, 2'b11);
      chk("os_done_busy",  u_if.busy,  1'b0);
      tick();
      chk("os_done_pulse", u_if.done,  1'b0);
      chk("os_hold_count", u_if.count, 4'd7);
      chk("os_hold_state", u_if.state, 2'b11);

      // ---- ignored commands in DONE ----
      u_if.cmd_start = 1'b1; u_if.cmd_stop = 1'b1; tick();
      u_if.cmd_start = 1'b0; u_if.cmd_stop = 1'b0;
      chk("done_both_state", u_if.state, 2'b11);
      chk("done_both_count", u_if.count, 4'd7);
      u_if.cmd_stop = 1'b1; tick(); u_if.cmd_stop = 1'b0;
      chk("done_stop_state", u_if.state, 2'b11);

      // ---- auto-reload with prescale, 15 wraps to 0 = terminal ----
      u_if.load_val = 4'd14; u_if.terminal = 4'd0; u_if.presc = 4'd2; u_if.mode_reload = 1'b1;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("rl_load",  u_if.count, 4'd14);
      chk("rl_state", u_if.state, 2'b01);
      tick(); tick();
      chk("rl_wait",  u_if.count, 4'd14);
      tick();
      chk("rl_adv1",  u_if.count, 4'd15);
      chk("rl_nodone", u_if.done, 1'b0);
      tick(); tick();
      chk("rl_wait2", u_if.count, 4'd15);
      tick();
      chk("rl_reload", u_if.count, 4'd14);
      chk("rl_done",   u_if.done,  1'b1);
      chk("rl_state2", u_if.state, 2'b01);
      tick();
      chk("rl_done_pulse", u_if.done,  1'b0);
      chk("rl_count_hold", u_if.count, 4'd14);

      // ---- stop RUN -> PAUSE, stop PAUSE -> IDLE ----
      u_if.cmd_stop = 1'b1; tick(); u_if.cmd_stop = 1'b0;
      chk("pause_state", u_if.state, 2'b10);
      chk("pause_busy",  u_if.busy,  1'b1);
      chk("pause_count", u_if.count, 4'd14);
      u_if.cmd_stop = 1'b1; tick(); u_if.cmd_stop = 1'b0;
      chk("abort_state", u_if.state, 2'b00);
      chk("abort_count", u_if.count, 4'd14);
      chk("abort_busy",  u_if.busy,  1'b0);
      u_if.cmd_start = 1'b1; u_if.cmd_stop = 1'b1; tick();
      u_if.cmd_start = 1'b0; u_if.cmd_stop = 1'b0;
      chk("idle_both_state", u_if.state, 2'b00);
      chk("idle_both_count", u_if.count, 4'd14);

      // ---- pause/resume with prescaler mid-way ----
      u_if.load_val = 4'd3; u_if.terminal = 4'd9; u_if.presc = 4'd3; u_if.mode_reload = 1'b0;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("pr_load", u_if.count, 4'd3);
      repeat (3) tick();
      chk("pr_wait", u_if.count, 4'd3);
      tick();
      chk("pr_adv4", u_if.count, 4'd4);
      repeat (4) tick();
      chk("pr_adv5", u_if.count, 4'd5);
      tick();
      u_if.cmd_stop = 1'b1; tick(); u_if.cmd_stop = 1'b0;
      chk("pr_paused", u_if.state, 2'b10);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("pr_hold_count", u_if.count, 4'd5);
      end
      chk("pr_hold_state", u_if.state, 2'b10);
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("pr_resume_state", u_if.state, 2'b01);
      chk("pr_resume_count", u_if.count, 4'd5);
      tick();
      chk("pr_resume_wait", u_if.count, 4'd5);
      tick();
      chk("pr_resume_adv", u_if.count, 4'd6);
      chk("pr_resume_nodone", u_if.done, 1'b0);

      // ---- stop coincides with the advance to terminal, one-shot ----
      u_if.presc = 4'd0;
      tick();
      chk("ps_adv7", u_if.count, 4'd7);
      tick();
      chk("ps_adv8", u_if.count, 4'd8);
      u_if.cmd_stop = 1'b1; tick(); u_if.cmd_stop = 1'b0;
      chk("ps_count", u_if.count, 4'd9);
      chk("ps_done",  u_if.done,  1'b1);
      chk("ps_state", u_if.state, 2'b11);

      // ---- load == terminal runs a full 16 advances; start in RUN ignored ----
      u_if.load_val = 4'd2; u_if.terminal = 4'd2; u_if.presc = 4'd0; u_if.mode_reload = 1'b0;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("fw_load", u_if.count, 4'd2);
      chk("fw_nodone_load", u_if.done, 1'b0);
      repeat (5) tick();
      chk("fw_mid", u_if.count, 4'd7);
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("fw_start_ign", u_if.count, 4'd8);
      chk("fw_start_state", u_if.state, 2'b01);
      repeat (9) tick();
      chk("fw_wrapped", u_if.count, 4'd1);
      chk("fw_nodone", u_if.done, 1'b0);
      tick();
      chk("fw_term", u_if.count, 4'd2);
      chk("fw_done", u_if.done,  1'b1);
      chk("fw_state", u_if.state, 2'b11);

      // ---- async reset mid-RUN ----
      u_if.load_val = 4'd5; u_if.terminal = 4'd12; u_if.presc = 4'd7;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("ar_pre_count", u_if.count, 4'd5);
      chk("ar_pre_state", u_if.state, 2'b01);
      #3 reset = 1'b1;
      #1;
      chk("ar_count", u_if.count, 4'd0);
      chk("ar_state", u_if.state, 2'b00);
      chk("ar_busy",  u_if.busy,  1'b0);
      chk("ar_done",  u_if.done,  1'b0);
      tick();
      reset = 1'b0;
      tick();
      chk("ar_after_state", u_if.state, 2'b00);
      chk("ar_after_count", u_if.count, 4'd0);

`ifdef COUNT_DOWN_EN
      // ---- down-count 1,0,15,14 ----
      u_if.dir = 1'b1; u_if.load_val = 4'd1; u_if.terminal = 4'd14;
      u_if.presc = 4'd0; u_if.mode_reload = 1'b0;
      u_if.cmd_start = 1'b1; tick(); u_if.cmd_start = 1'b0;
      chk("dn_load", u_if.count, 4'd1);
      tick();
      chk("dn_zero", u_if.count, 4'd0);
      tick();
      chk("dn_wrap", u_if.count, 4'd15);
      chk("dn_nodone", u_if.done, 1'b0);
      tick();
      chk("dn_term",  u_if.count, 4'd14);
      chk("dn_done",  u_if.done,  1'b1);
      chk("dn_state", u_if.state, 2'b11);
      u_if.dir = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
